// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: default frame geometry, read FSM states,
// index-width derivation and bit-reversal helper.
package fft_bitrev_reorder_pkg;

  localparam int N_DEFAULT     = 32;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_t;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Reverses the low 'bits' bits of value; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[i] = value[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_buf_ram.sv
// Simple dual-port frame buffer: synchronous write, synchronous read, no reset.
// Read data appears one cycle after rd_en; no backpressure.
module fft_buf_ram #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder of bit-reversed SDF FFT frames into natural order.
// Index 0 leaves 2 edges after the last sample is captured; no backpressure, output streams N cycles.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter  int N     = N_DEFAULT,
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int LOG2N = log2_ceil(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_in,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    enable_out,
  output logic                    frame_start,
  output logic [LOG2N-1:0]        out_index,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  logic [LOG2N-1:0]   wcnt;
  logic               wbank;
  rd_state_t          state;
  logic [LOG2N-1:0]   rcnt;
  logic               rbank;
  logic               rd_vld;
  logic [LOG2N-1:0]   rd_idx;
  logic               trigger;
  logic               rd_en;
  logic [LOG2N:0]     wr_addr;
  logic [LOG2N:0]     rd_addr;
  logic [2*WIDTH-1:0] rd_dat;

  assign trigger = enable_in && (wcnt == LOG2N'(N - 1));
  assign rd_en   = (state == RD_READ);
  assign wr_addr = {wbank, wcnt};
  assign rd_addr = {rbank, LOG2N'(bitrev(32'(rcnt), LOG2N))};

  fft_buf_ram #(
    .AW (LOG2N + 1),
    .DW (2 * WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (enable_in),
    .wr_addr (wr_addr),
    .wr_dat  ({in_re, in_im}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  // wcnt wraps naturally because N is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (enable_in) begin
      wcnt <= wcnt + LOG2N'(1);
      if (trigger) wbank <= ~wbank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RD_IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (trigger) begin
            state <= RD_READ;
            rcnt  <= '0;
            rbank <= wbank;
          end
        end
        RD_READ: begin
          // A trigger on the last read chains straight into the other bank.
          if (trigger) begin
            rcnt  <= '0;
            rbank <= wbank;
          end else if (rcnt == LOG2N'(N - 1)) begin
            state <= RD_IDLE;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + LOG2N'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld      <= 1'b0;
      rd_idx      <= '0;
      enable_out  <= 1'b0;
      frame_start <= 1'b0;
      out_index   <= '0;
      out_re      <= '0;
      out_im      <= '0;
    end else begin
      rd_vld      <= rd_en;
      rd_idx      <= rcnt;
      enable_out  <= rd_vld;
      frame_start <= rd_vld && (rd_idx == '0);
      if (rd_vld) begin
        out_index <= rd_idx;
        out_re    <= rd_dat[2*WIDTH-1:WIDTH];
        out_im    <= rd_dat[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: driver pushes natural-order
// expectations per completed frame, a negedge monitor pops and compares.
module tb_fft_bitrev_reorder;

  localparam int N  = 32;
  localparam int W  = 8;
  localparam int LG = 5;

  logic         clk;
  logic         rst;
  logic         enable_in;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         enable_out;
  logic         frame_start;
  logic [LG-1:0] out_index;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;

  fft_bitrev_reorder #(.N(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_in   (enable_in),
    .in_re       (in_re),
    .in_im       (in_im),
    .enable_out  (enable_out),
    .frame_start (frame_start),
    .out_index   (out_index),
    .out_re      (out_re),
    .out_im      (out_im)
  );

  int     compared   = 0;
  int     mismatched = 0;
  longint cyc        = 0;

  int         q_idx[$];
  logic [7:0] q_re[$];
  logic [7:0] q_im[$];
  longint     q_cyc[$];
  logic [7:0] mdl_re[$];
  logic [7:0] mdl_im[$];
  logic [7:0] fr_re[N];
  logic [7:0] fr_im[N];
  logic [7:0] last_re;
  logic [7:0] last_im;

  int         e_idx;
  logic [7:0] e_re;
  logic [7:0] e_im;
  longint     e_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_bitrev(input int n);
    int r;
    int x;
    r = 0;
    x = n;
    for (int b = 0; b < LG; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One input cycle; a completed frame queues its natural-order expectations.
  task automatic send_cycle(input logic en, input logic [7:0] re, input logic [7:0] im);
    enable_in = en;
    in_re     = re;
    in_im     = im;
    @(posedge clk);
    #1;
    if (en) begin
      mdl_re.push_back(re);
      mdl_im.push_back(im);
      if (mdl_re.size() == N) begin
        for (int n = 0; n < N; n++) begin
          q_idx.push_back(n);
          q_re.push_back(mdl_re[ref_bitrev(n)]);
          q_im.push_back(mdl_im[ref_bitrev(n)]);
          q_cyc.push_back(cyc + 2 + n);
        end
        mdl_re.delete();
        mdl_im.delete();
      end
    end
  endtask

  // gap_mode: 0 contiguous, 1 one idle cycle after every sample, 2 random gaps
  task automatic send_frame(input int gap_mode);
    for (int k = 0; k < N; k++) begin
      send_cycle(1'b1, fr_re[k], fr_im[k]);
      if (gap_mode == 1) send_cycle(1'b0, 8'($urandom), 8'($urandom));
      if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) send_cycle(1'b0, 8'($urandom), 8'($urandom));
      end
    end
    enable_in = 1'b0;
  endtask

  task automatic flush_model();
    q_idx.delete();
    q_re.delete();
    q_im.delete();
    q_cyc.delete();
    mdl_re.delete();
    mdl_im.delete();
    last_re = '0;
    last_im = '0;
  endtask

  task automatic pulse_reset();
    enable_in = 1'b0;
    rst = 1'b1;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (q_idx.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk(name, q_idx.size(), 0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) send_cycle(1'b0, 8'($urandom), 8'($urandom));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (enable_out) begin
        if (q_idx.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: index %0d re %0d im %0d, no output expected", out_index, out_re, out_im);
        end else begin
          e_idx = q_idx.pop_front();
          e_re  = q_re.pop_front();
          e_im  = q_im.pop_front();
          e_cyc = q_cyc.pop_front();
          chk("out_index", out_index, e_idx);
          chk("out_re", out_re, e_re);
          chk("out_im", out_im, e_im);
          chk("frame_start", frame_start, (e_idx == 0) ? 1 : 0);
          chk("out_cycle", cyc, e_cyc);
        end
        last_re = out_re;
        last_im = out_im;
      end else begin
        chk("idle_hold_re", out_re, last_re);
        chk("idle_hold_im", out_im, last_im);
        chk("idle_frame_start", frame_start, 0);
      end
    end
  end

  initial begin
    int found;
    rst       = 1'b0;
    enable_in = 1'b0;
    in_re     = '0;
    in_im     = '0;
    last_re   = '0;
    last_im   = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset_enable_out", enable_out, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_out_index", out_index, 0);
    chk("reset_out_re", out_re, 0);
    chk("reset_out_im", out_im, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Ramp frame: re=k, im=-k
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 8'(k);
      fr_im[k] = 8'(0 - k);
    end
    send_frame(0);
    wait_drain("drain_ramp");
    idle(3);

    // Two back-to-back frames, second offset by 32
    send_frame(0);
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 8'(k + 32);
      fr_im[k] = 8'(0 - k);
    end
    send_frame(0);
    wait_drain("drain_b2b");
    idle(3);

    // Ramp frame with an idle cycle after every sample
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 8'(k);
      fr_im[k] = 8'(0 - k);
    end
    send_frame(1);
    wait_drain("drain_gapped");
    idle(3);

    // Partial frame discarded by reset, then a fresh random frame
    for (int k = 0; k < 10; k++) send_cycle(1'b1, 8'(k), 8'(0 - k));
    pulse_reset();
    idle(40);
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 8'($urandom);
      fr_im[k] = 8'($urandom);
    end
    send_frame(0);
    wait_drain("drain_after_reset");
    idle(3);

    // Full-scale alternating extremes
    for (int k = 0; k < N; k++) begin
      fr_re[k] = (k % 2 == 1) ? 8'h7F : 8'h80;
      fr_im[k] = (k % 2 == 1) ? 8'h80 : 8'h7F;
    end
    send_frame(0);
    wait_drain("drain_extremes");
    idle(3);

    // Random frames with random gaps, chained
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        fr_re[k] = 8'($urandom);
        fr_im[k] = 8'($urandom);
      end
      send_frame(2);
    end
    wait_drain("drain_random");
    idle(3);

    // Reset during readout at index 12
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 8'(k + 1);
      fr_im[k] = 8'(0 - k - 1);
    end
    send_frame(0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (enable_out && out_index == 5'd12) begin
        found = 1;
        break;
      end
    end
    chk("reach_index_12", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("midread_rst_enable_out", enable_out, 0);
    chk("midread_rst_out_re", out_re, 0);
    chk("midread_rst_out_im", out_im, 0);
    chk("midread_rst_frame_start", frame_start, 0);
    flush_model();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(60);
    chk("no_residual_pending", q_idx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output stage placed directly downstream of the radix-2^2 SDF FFT core.
- The SDF pipeline emits each N-point frame in bit-reversed index order; this block buffers each frame and re-emits it in natural order.
- Uses a ping-pong buffer: one bank fills in arrival order while the other bank is read out at bit-reversed addresses.
- Data passes through unmodified (no scaling or rounding).

Parameters:
- N, 32, FFT points per frame; power of two, >= 4.
- WIDTH, 8, bit width of each signed real/imag component.
- LOG2N, $clog2(N), local (derived, not overridable); address and index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable_in  input  1  in_re/in_im carry a valid sample this cycle.
- in_re  input  WIDTH  signed real part, bit-reversed frame order.
- in_im  input  WIDTH  signed imaginary part.
- enable_out  output  1  out_re/out_im valid this cycle.
- frame_start  output  1  high with natural-order output index 0.
- out_index  output  LOG2N  natural-order index of the current output sample.
- out_re  output  WIDTH  signed real part, natural order.
- out_im  output  WIDTH  signed imaginary part.

Behaviour:
- Reset (async, immediate effect):
  - Outputs: enable_out=0, frame_start=0, out_index=0, out_re=0, out_im=0.
  - State: write counter=0, write bank=0, read FSM=IDLE.
  - Buffer contents are don't-care; any partially written frame is discarded.
- Write side:
  - Each enable_in=1 cycle writes {in_re,in_im} to buffer[wbank][wcnt], then increments wcnt.
  - While enable_in=0, wcnt holds; gaps are allowed anywhere in a frame.
  - When the write at wcnt=N-1 occurs: wcnt wraps to 0, wbank toggles, and a read of the just-filled bank is triggered.
- Read FSM has two states, IDLE and READ:
  - IDLE -> READ on trigger; rcnt=0.
  - In READ, rcnt increments each cycle; read address = bitrev(rcnt) in the filled bank.
  - READ -> IDLE after rcnt=N-1, unless a new trigger occurs in that same cycle. In that case the FSM stays in READ with rcnt=0 on the other bank.
- Memory read is synchronous, followed by a registered output. Sample n is therefore valid 2 cycles after its read address is issued.
- Latency: output index 0 appears on the 2nd rising edge after the edge that captured input sample N-1.
  - enable_out is then high for exactly N consecutive cycles.
  - out_index runs 0..N-1 over those cycles; frame_start is high only with index 0.
- Mapping: output n = input sample received at position bitrev_LOG2N(n).
- Back-to-back frames:
  - Continuous input produces continuous output with no gap between frames.
  - Overlap is impossible: the next trigger needs at least N write cycles, and a readout lasts N cycles.
- Idle output data: while enable_out=0, out_re/out_im hold their last value.
- Reset mid-readout: enable_out drops immediately. No further outputs appear until a new full frame has been written after reset.

Decomposition:
- Shared fft package holds:
  - bitrev function, parameterised by LOG2N;
  - N and WIDTH defaults;
  - the LOG2N derivation helper.
- One sub-module, fft_buf_ram:
  - simple dual-port RAM, 2N deep, 2*WIDTH wide;
  - bank select is the address MSB;
  - synchronous write and synchronous read, no reset.

Test Plan (N=32, WIDTH=8):
1. Reset, then 32 contiguous samples with in_re=k, in_im=-k at position k.
   - enable_out high 32 cycles, starting 2 edges after the last input.
   - out_re sequence is 0,16,8,24,4,20,...,31; out_im is its negation.
   - frame_start high only on the first output; out_index 0..31.
2. Two back-to-back frames, second frame with in_re=k+32.
   - 64 consecutive enable_out cycles with no gap.
   - Second burst out_re = 32+bitrev(n).
3. Same frame as test 1 with enable_in toggling 1,0,1,0.
   - Identical output values and order.
   - Output burst is still 32 contiguous cycles.
4. Assert rst after 10 input samples, then send a full fresh frame.
   - No enable_out during or after the partial frame.
   - The fresh frame is output correctly.
5. Frame alternating -128 and 127 on re and im.
   - Values appear unchanged at the bit-reversal-mapped output indices.
6. Assert rst during readout at out_index=12.
   - enable_out=0 and out_re/out_im=0 before the next clock edge.
   - No residual outputs afterwards.
